// File: rtl/bit_stuff_tx.sv
// Serialiser that sends a parallel word MSB first and inserts an inverted bit after RUN_LIMIT equal line bits.
// Stuffing and run tracking are present only when BIT_STUFF_TX_STUFF_EN is defined.
module bit_stuff_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RUN_LIMIT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             a,
  output logic             a_valid,
  output logic             stuff,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef BIT_STUFF_TX_STUFF_EN
  localparam logic [1:0] STUFF = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    left_q, left_d;
  logic             a_d, a_valid_d, stuff_d, ready_d;
  logic             accept, emit, emit_bit, go_idle;
`ifdef BIT_STUFF_TX_STUFF_EN
  logic             last_q, last_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             need_stuff;
`endif

  // Next-state and next-output logic; ready_out is precomputed for the cycle being entered.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    left_d    = left_q;
    a_d       = a;
    a_valid_d = a_valid;
    stuff_d   = 1'b0;
    emit      = 1'b0;
    emit_bit  = 1'b0;
    go_idle   = 1'b0;
    accept    = valid_in & ready_out;
`ifdef BIT_STUFF_TX_STUFF_EN
    last_d     = last_q;
    cnt_d      = cnt_q;
    need_stuff = (state_q == SHIFT) && (cnt_q == 3'(RUN_LIMIT));
`endif

    if (accept) begin
      emit     = 1'b1;
      emit_bit = data_in[WIDTH-1];
      sreg_d   = data_in << 1;
      left_d   = CW'(WIDTH - 1);
      state_d  = SHIFT;
    end else begin
      case (state_q)
        SHIFT: begin
`ifdef BIT_STUFF_TX_STUFF_EN
          if (need_stuff) begin
            state_d   = STUFF;
            a_d       = ~last_q;
            a_valid_d = 1'b1;
            stuff_d   = 1'b1;
            last_d    = ~last_q;
            cnt_d     = 3'd1;
          end else
`endif
          if (left_q != '0) begin
            emit     = 1'b1;
            emit_bit = sreg_q[WIDTH-1];
            sreg_d   = sreg_q << 1;
            left_d   = left_q - CW'(1);
          end else begin
            go_idle = 1'b1;
          end
        end
`ifdef BIT_STUFF_TX_STUFF_EN
        STUFF: begin
          if (left_q != '0) begin
            emit     = 1'b1;
            emit_bit = sreg_q[WIDTH-1];
            sreg_d   = sreg_q << 1;
            left_d   = left_q - CW'(1);
            state_d  = SHIFT;
          end else begin
            go_idle = 1'b1;
          end
        end
`endif
        default: go_idle = 1'b1;
      endcase
    end

    if (emit) begin
      a_d       = emit_bit;
      a_valid_d = 1'b1;
`ifdef BIT_STUFF_TX_STUFF_EN
      cnt_d  = ((cnt_q != 3'd0) && (emit_bit == last_q)) ? cnt_q + 3'd1 : 3'd1;
      last_d = emit_bit;
`endif
    end

    if (go_idle) begin
      state_d   = IDLE;
      a_d       = 1'b0;
      a_valid_d = 1'b0;
      sreg_d    = '0;
      left_d    = '0;
`ifdef BIT_STUFF_TX_STUFF_EN
      cnt_d  = 3'd0;
      last_d = 1'b0;
`endif
    end

    // A word may follow only once no stuff bit is pending for its final data bit.
`ifdef BIT_STUFF_TX_STUFF_EN
    ready_d = (state_d == IDLE) ||
              ((left_d == '0) && ((state_d == STUFF) ||
                                  ((state_d == SHIFT) && (cnt_d != 3'(RUN_LIMIT)))));
`else
    ready_d = (state_d == IDLE) || ((left_d == '0) && (state_d == SHIFT));
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      left_q    <= '0;
      a         <= 1'b0;
      a_valid   <= 1'b0;
      stuff     <= 1'b0;
      ready_out <= 1'b1;
      busy      <= 1'b0;
`ifdef BIT_STUFF_TX_STUFF_EN
      cnt_q  <= 3'd0;
      last_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      left_q    <= left_d;
      a         <= a_d;
      a_valid   <= a_valid_d;
      stuff     <= stuff_d;
      ready_out <= ready_d;
      busy      <= (state_d != IDLE);
`ifdef BIT_STUFF_TX_STUFF_EN
      cnt_q  <= cnt_d;
      last_q <= last_d;
`endif
    end
  end

endmodule

// File: doc/bit_stuff_tx.md
BIT_STUFF_TX -- requirements
Module: bit_stuff_tx

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits; legal range 2..16.
REQ-002 Parameter RUN_LIMIT, default 3: maximum count of equal consecutive line bits before a stuff bit; legal range 2..7.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 data_in  input  WIDTH  parallel word to transmit, MSB first.
REQ-006 valid_in  input  1  data_in is valid this cycle.
REQ-007 ready_out  output  1  block accepts data_in this cycle; transfer occurs when valid_in & ready_out at posedge.
REQ-008 a  output  1  serial line bit, registered.
REQ-009 a_valid  output  1  a carries a transmitted bit this cycle, registered.
REQ-010 stuff  output  1  current a is an inserted stuff bit, registered; only asserted together with a_valid.
REQ-011 busy  output  1  state is not IDLE.

Function
REQ-012 The block shall use states IDLE, SHIFT, STUFF.
REQ-013 IDLE: ready_out=1; on accept, load the word into the shift register and go to SHIFT; the first bit (data_in[WIDTH-1]) appears on a with a_valid=1 in the cycle after the accepting edge.
REQ-014 SHIFT: emit one data bit per cycle, MSB first, with a_valid=1 and stuff=0.
REQ-015 The block shall track last line bit and run count (1..RUN_LIMIT), counting both data and stuff bits.
REQ-016 When an emitted bit brings run count to RUN_LIMIT, the next cycle shall be STUFF: a = inverse of that bit, a_valid=1, stuff=1; run count becomes 1 with the new bit value.
REQ-017 After STUFF, return to SHIFT if data bits remain, else behave as end of word (REQ-018).
REQ-018 End of word: ready_out=1 during the last data bit cycle only if that bit does not require a stuff bit; otherwise ready_out=1 during the resulting STUFF cycle.
REQ-019 Back-to-back: accept at end of word with no gap cycle; run history carries over into the next word.
REQ-020 Without an accept at end of word, go to IDLE; a_valid=0, a=0, stuff=0 in IDLE; run history cleared (count 0).
REQ-021 ready_out shall be 0 in all other SHIFT/STUFF cycles; valid_in while ready_out=0 shall be ignored.
REQ-022 Line bits per word = WIDTH + number of stuff bits; the stuffed stream shall never contain more than RUN_LIMIT equal consecutive bits.

Reset
REQ-023 On reset: state IDLE, a=0, a_valid=0, stuff=0, busy=0, ready_out=1 in the following cycle, run count 0, shift register 0.
REQ-024 Reset mid-word shall discard the word and any pending stuff bit; reset shall have priority over accept.

Configuration
REQ-025 Macro BIT_STUFF_TX_STUFF_EN defined: stuffing per REQ-015..REQ-018.
REQ-026 Macro undefined: STUFF state and run tracking removed; each word takes exactly WIDTH cycles, stuff tied to 0, ready_out=1 in the last data bit cycle.

Verification (WIDTH=8, RUN_LIMIT=3, macro defined unless stated)
REQ-027 Accept 8'hA5 from IDLE -> a = 1,0,1,0,0,1,0,1 over 8 cycles, stuff=0, then IDLE.
REQ-028 Accept 8'hFF -> a = 1,1,1,0s,1,1,1,0s,1,1 (s = stuff=1), 10 cycles.
REQ-029 8'hF0 then 8'h0F back-to-back -> 1,1,1,0s,1,0,0,0,1s,0 then 0,0,1s,0,0,1,1,1,0s,1; no gap cycle between words.
REQ-030 Reset asserted at the 4th bit of 8'h00 -> next cycle a_valid=0, busy=0, ready_out=1; the next word 8'h00 yields 0,0,0,1s,0,0,0,1s,0,0.
REQ-031 Macro undefined, accept 8'hFF -> eight 1s, stuff=0 throughout, ready_out=1 on the 8th bit.
REQ-032 valid_in held high during SHIFT with changing data_in -> only words present at ready_out=1 edges are transmitted.
